// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the PLL-lock driven reset sequencer.
package reset_seq_pkg;

    localparam int unsigned LOST_CNT_W = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLDOFF   = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3
    } seq_state_t;

    // Bits needed to hold every value in 0..max_val (never less than one).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, async active-low clear.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release driven by a filtered PLL lock flag, with lock-loss accounting.
// Define RESET_SEQ_FAST_SIM_EN to clamp holdoff and stage gap for short simulations.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned HOLDOFF     = 1024,
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned STAGE_GAP   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  ready,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt,
    output logic [2:0]            seq_state
);

`ifdef RESET_SEQ_FAST_SIM_EN
    localparam int unsigned HOLD_EFF = (HOLDOFF > 16) ? 16 : HOLDOFF;
    localparam int unsigned GAP_EFF  = (STAGE_GAP > 4) ? 4 : STAGE_GAP;
`else
    localparam int unsigned HOLD_EFF = HOLDOFF;
    localparam int unsigned GAP_EFF  = STAGE_GAP;
`endif

    localparam int unsigned FILT_W  = cnt_width(LOCK_FILTER);
    localparam int unsigned HOLD_W  = cnt_width(HOLD_EFF);
    localparam int unsigned GAP_W   = cnt_width(GAP_EFF);
    localparam int unsigned STAGE_W = cnt_width(NUM_STAGES);

    localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
    localparam logic [FILT_W-1:0]  FILT_MAX   = FILT_W'(LOCK_FILTER);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_EFF);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_EFF - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

    logic lock_s;
    logic seq_active;

    seq_state_t            state_q, state_d;
    logic [FILT_W-1:0]     filt_q, filt_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [STAGE_W-1:0]    stage_q, stage_d;
    logic [NUM_STAGES-1:0] rst_out_n_q, rst_out_n_d;
    logic                  ready_q, ready_d;
    logic [LOST_CNT_W-1:0] lost_q, lost_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    // The HOLDOFF parameter shadows the imported state name, so the state is package-qualified.
    assign seq_active = (state_q == reset_seq_pkg::HOLDOFF) || (state_q == RELEASE) ||
                        (state_q == RUN);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        stage_d     = stage_q;
        rst_out_n_d = rst_out_n_q;
        ready_d     = ready_q;
        lost_d      = lost_q;

        if (!lock_s) begin
            filt_d = '0;
        end else if (filt_q == FILT_MAX) begin
            filt_d = filt_q;
        end else begin
            filt_d = filt_q + 1'b1;
        end

        // Lock loss outranks a coincident software request.
        if (seq_active && !lock_s) begin
            state_d     = WAIT_LOCK;
            rst_out_n_d = '0;
            ready_d     = 1'b0;
            filt_d      = '0;
            if (lost_q != '1) begin
                lost_d = lost_q + 1'b1;
            end
        end else if (seq_active && sw_reset_req) begin
            state_d     = reset_seq_pkg::HOLDOFF;
            rst_out_n_d = '0;
            ready_d     = 1'b0;
            hold_d      = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    rst_out_n_d = '0;
                    ready_d     = 1'b0;
                    if (lock_s && (filt_q == FILT_LAST)) begin
                        state_d = reset_seq_pkg::HOLDOFF;
                        hold_d  = '0;
                    end
                end
                reset_seq_pkg::HOLDOFF: begin
                    if (hold_q == HOLD_LAST) begin
                        gap_d   = '0;
                        stage_d = STAGE_W'(1);
                        if (NUM_STAGES == 1) begin
                            state_d     = RUN;
                            rst_out_n_d = '1;
                            ready_d     = 1'b1;
                        end else begin
                            state_d     = RELEASE;
                            rst_out_n_d = NUM_STAGES'(1);
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d       = '0;
                        stage_d     = stage_q + 1'b1;
                        rst_out_n_d = rst_out_n_q | (NUM_STAGES'(1) << stage_q);
                        if (stage_q == STAGE_LAST) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d     = WAIT_LOCK;
                    rst_out_n_d = '0;
                    ready_d     = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            filt_q      <= '0;
            hold_q      <= '0;
            gap_q       <= '0;
            stage_q     <= '0;
            rst_out_n_q <= '0;
            ready_q     <= 1'b0;
            lost_q      <= '0;
        end else begin
            state_q     <= state_d;
            filt_q      <= filt_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            stage_q     <= stage_d;
            rst_out_n_q <= rst_out_n_d;
            ready_q     <= ready_d;
            lost_q      <= lost_d;
        end
    end

    assign rst_out_n     = rst_out_n_q;
    assign ready         = ready_q;
    assign lock_lost_cnt = lost_q;
    assign seq_state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Table-driven, scoreboarded bench for reset_sequencer (small holdoff/gap parameters).
module tb_reset_sequencer;

    localparam int unsigned NS = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          pll_locked = 1'b0;
    logic          sw_reset_req = 1'b0;
    logic [NS-1:0] rst_out_n;
    logic          ready;
    logic [7:0]    lock_lost_cnt;
    logic [2:0]    seq_state;

    typedef struct {
        string       name;
        logic        pll;
        logic        sw;
        int unsigned n;
        logic [2:0]  rst;
        logic        rdy;
        logic [7:0]  cnt;
        logic [2:0]  st;
    } vec_t;

    typedef struct packed {
        logic [2:0] rst;
        logic       rdy;
        logic [7:0] cnt;
        logic [2:0] st;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    vec_t  cold_tbl[$];
    vec_t  loss_tbl[$];
    vec_t  sw_tbl[$];
    vec_t  simul_tbl[$];
    vec_t  bounce_tbl[$];
    int    checks = 0;
    int    failures = 0;
    logic [7:0] exp_cnt;

    reset_sequencer #(
        .SYNC_STAGES (2),
        .LOCK_FILTER (4),
        .HOLDOFF     (10),
        .NUM_STAGES  (NS),
        .STAGE_GAP   (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .sw_reset_req  (sw_reset_req),
        .rst_out_n     (rst_out_n),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt),
        .seq_state     (seq_state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic pll, input logic sw,
                                input int unsigned n, input logic [2:0] rst, input logic rdy,
                                input logic [7:0] cnt, input logic [2:0] st);
        vec_t v;
        v.name = name;
        v.pll  = pll;
        v.sw   = sw;
        v.n    = n;
        v.rst  = rst;
        v.rdy  = rdy;
        v.cnt  = cnt;
        v.st   = st;
        return v;
    endfunction

    task automatic push_exp(input string nm, input logic [2:0] rst, input logic rdy,
                            input logic [7:0] cnt, input logic [2:0] st);
        exp_t e;
        e.rst = rst;
        e.rdy = rdy;
        e.cnt = cnt;
        e.st  = st;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_pop();
        exp_t  e;
        exp_t  act;
        string nm;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {rst_out_n, ready, lock_lost_cnt, seq_state};
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got rst_out_n=%b ready=%b cnt=%0d state=%0d, required rst_out_n=%b ready=%b cnt=%0d state=%0d",
                         nm, act.rst, act.rdy, act.cnt, act.st, e.rst, e.rdy, e.cnt, e.st);
            end
        end
    endtask

    // Drive one vector for v.n edges; outputs are sampled on the falling edge after the last.
    task automatic apply(input vec_t v);
        pll_locked   = v.pll;
        sw_reset_req = v.sw;
        push_exp(v.name, v.rst, v.rdy, v.cnt, v.st);
        repeat (v.n) begin
            @(negedge clk);
            sw_reset_req = 1'b0;
        end
        check_pop();
    endtask

    task automatic run_cold(input logic [7:0] cnt);
        vec_t v;
        foreach (cold_tbl[i]) begin
            v     = cold_tbl[i];
            v.cnt = cnt;
            apply(v);
        end
    endtask

    task automatic async_reset(input string nm);
        rst_n = 1'b0;
        #1;
        push_exp(nm, 3'b000, 1'b0, 8'd0, 3'd0);
        check_pop();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Edge 0 is the first rising edge that samples pll_locked high.
        cold_tbl.push_back(mk("cold_filter",   1, 0, 5,  3'b000, 0, 0, 3'd0));
        cold_tbl.push_back(mk("cold_holdoff",  1, 0, 1,  3'b000, 0, 0, 3'd1));
        cold_tbl.push_back(mk("cold_hold_end", 1, 0, 10, 3'b000, 0, 0, 3'd1));
        cold_tbl.push_back(mk("cold_bit0",     1, 0, 1,  3'b001, 0, 0, 3'd2));
        cold_tbl.push_back(mk("cold_bit0_hld", 1, 0, 2,  3'b001, 0, 0, 3'd2));
        cold_tbl.push_back(mk("cold_bit1",     1, 0, 1,  3'b011, 0, 0, 3'd2));
        cold_tbl.push_back(mk("cold_bit1_hld", 1, 0, 2,  3'b011, 0, 0, 3'd2));
        cold_tbl.push_back(mk("cold_run",      1, 0, 1,  3'b111, 1, 0, 3'd3));
        cold_tbl.push_back(mk("cold_run_hld",  1, 0, 5,  3'b111, 1, 0, 3'd3));

        loss_tbl.push_back(mk("loss_sync",     0, 0, 2,  3'b111, 1, 0, 3'd3));
        loss_tbl.push_back(mk("loss_hit",      0, 0, 1,  3'b000, 0, 1, 3'd0));
        loss_tbl.push_back(mk("loss_wait",     0, 0, 3,  3'b000, 0, 1, 3'd0));
        loss_tbl.push_back(mk("loss_sw_ign",   0, 1, 1,  3'b000, 0, 1, 3'd0));
        loss_tbl.push_back(mk("loss_wait2",    0, 0, 2,  3'b000, 0, 1, 3'd0));

        sw_tbl.push_back(mk("sw_req",          1, 1, 1,  3'b000, 0, 1, 3'd1));
        sw_tbl.push_back(mk("sw_hold",         1, 0, 10, 3'b000, 0, 1, 3'd1));
        sw_tbl.push_back(mk("sw_bit0",         1, 0, 1,  3'b001, 0, 1, 3'd2));
        sw_tbl.push_back(mk("sw_bit0_hld",     1, 0, 2,  3'b001, 0, 1, 3'd2));
        sw_tbl.push_back(mk("sw_bit1",         1, 0, 1,  3'b011, 0, 1, 3'd2));
        sw_tbl.push_back(mk("sw_bit1_hld",     1, 0, 2,  3'b011, 0, 1, 3'd2));
        sw_tbl.push_back(mk("sw_run",          1, 0, 1,  3'b111, 1, 1, 3'd3));

        simul_tbl.push_back(mk("both_sync",    0, 0, 2,  3'b111, 1, 1, 3'd3));
        simul_tbl.push_back(mk("both_hit",     0, 1, 1,  3'b000, 0, 2, 3'd0));
        simul_tbl.push_back(mk("both_wait",    0, 0, 2,  3'b000, 0, 2, 3'd0));

        bounce_tbl.push_back(mk("bnc_hi",      1, 0, 3,  3'b000, 0, 0, 3'd0));
        bounce_tbl.push_back(mk("bnc_lo",      0, 0, 1,  3'b000, 0, 0, 3'd0));
        bounce_tbl.push_back(mk("bnc_refilt",  1, 0, 5,  3'b000, 0, 0, 3'd0));
        bounce_tbl.push_back(mk("bnc_holdoff", 1, 0, 1,  3'b000, 0, 0, 3'd1));
        bounce_tbl.push_back(mk("bnc_hold_end",1, 0, 10, 3'b000, 0, 0, 3'd1));
        bounce_tbl.push_back(mk("bnc_bit0",    1, 0, 1,  3'b001, 0, 0, 3'd2));

        #1;
        async_reset("reset_init");

        run_cold(8'd0);
        foreach (loss_tbl[i]) apply(loss_tbl[i]);
        run_cold(8'd1);
        foreach (sw_tbl[i]) apply(sw_tbl[i]);
        foreach (simul_tbl[i]) apply(simul_tbl[i]);

        // Each round locks into HOLDOFF, then drops lock once.
        exp_cnt = 8'd2;
        for (int i = 0; i < 300; i++) begin
            apply(mk("sat_hi", 1, 0, 7, 3'b000, 0, exp_cnt, 3'd1));
            exp_cnt = (exp_cnt == 8'd255) ? 8'd255 : exp_cnt + 8'd1;
            apply(mk("sat_lo", 0, 0, 3, 3'b000, 0, exp_cnt, 3'd0));
        end
        apply(mk("sat_final", 0, 0, 1, 3'b000, 0, 8'd255, 3'd0));

        apply(mk("rel_mid", 1, 0, 18, 3'b001, 0, 8'd255, 3'd2));
        async_reset("reset_mid_release");
        run_cold(8'd0);

        pll_locked = 1'b0;
        async_reset("reset_pre_bounce");
        foreach (bounce_tbl[i]) apply(bounce_tbl[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, required finish (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
